// File: rtl/bnn_layer_sequencer_pkg.sv
// Shared types, default sizes and the popcount helper for the BNN layer sequencer.
package bnn_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DECIDE  = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int WORD_W_DEF    = 8;
  localparam int N_WORDS_DEF   = 4;
  localparam int N_NEURONS_DEF = 8;

  // Widest word the popcount helper accepts; callers zero-extend.
  localparam int POPCNT_MAX_W = 64;

  // Number of set bits in v.
  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// Handshake and weight-ROM bundle of the BNN layer sequencer.
// slave: the sequencer side; master: the environment (input stream, ROM, next layer).
interface bnn_layer_sequencer_if
  import bnn_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int N_WORDS   = N_WORDS_DEF,
  parameter int N_NEURONS = N_NEURONS_DEF
);
  localparam int ADDR_W = $clog2(N_NEURONS * N_WORDS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_W-1:0]    in_data;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_W-1:0]    w_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEURONS-1:0] out_bits;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_addr, out_valid, out_bits, busy
  );

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_addr, out_valid, out_bits, busy
  );

endinterface

// File: rtl/bnn_layer_sequencer_xnor_popcount.sv
// Combinational XNOR of an input word with a weight word, followed by a popcount:
// the number of bit positions where input and weight agree.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter  int WORD_W = WORD_W_DEF,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [CNT_W-1:0]  cnt
);

  logic [WORD_W-1:0] match;

  assign match = ~(a ^ b);
  assign cnt   = CNT_W'(popcount(POPCNT_MAX_W'(match)));

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexed binary layer: buffers one input vector, walks every neuron's
// weights from an external synchronous ROM, accumulates XNOR popcounts and
// thresholds each neuron into one bit of the layer result.
// Optional feature: define BNN_THRESH_CFG_EN for a writable per-neuron threshold file.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter  int WORD_W    = WORD_W_DEF,
  parameter  int N_WORDS   = N_WORDS_DEF,
  parameter  int N_NEURONS = N_NEURONS_DEF,
  localparam int ACC_W     = $clog2(WORD_W * N_WORDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bnn_layer_sequencer_if.slave          bus
`ifdef BNN_THRESH_CFG_EN
  ,
  input  logic                          cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]  cfg_idx,
  input  logic [ACC_W-1:0]              cfg_thresh
`endif
);

  localparam int ADDR_W = $clog2(N_NEURONS * N_WORDS);
  localparam int NW_W   = $clog2(N_WORDS);
  localparam int NN_W   = $clog2(N_NEURONS);
  localparam int PC_W   = $clog2(WORD_W + 1);
  localparam logic [ACC_W-1:0] THRESH_DEF = ACC_W'(WORD_W * N_WORDS / 2);

  state_t state_q, state_d;

  logic              in_ready_q;
  logic [NW_W-1:0]   word_cnt_q;
  logic [NW_W-1:0]   w_cnt_q;
  logic [NN_W-1:0]   n_cnt_q;
  logic [WORD_W-1:0] in_buf [N_WORDS];
  logic              pipe_vld_q;
  logic [NW_W-1:0]   pipe_w_q;
  logic [ACC_W-1:0]  acc_q;
  logic [N_NEURONS-1:0] out_bits_q;

  logic              in_fire;
  logic              last_word;
  logic              last_w;
  logic              last_n;
  logic [PC_W-1:0]   pc;
  logic [ACC_W-1:0]  acc_final;
  logic [ACC_W-1:0]  thresh_n;

  assign in_fire   = bus.in_valid & in_ready_q;
  assign last_word = (word_cnt_q == NW_W'(N_WORDS - 1));
  assign last_w    = (w_cnt_q == NW_W'(N_WORDS - 1));
  assign last_n    = (n_cnt_q == NN_W'(N_NEURONS - 1));

  // The ROM answers one cycle after the address, so the popcount pairs w_data
  // with the buffer word that was addressed in the previous cycle.
  bnn_xnor_popcount #(.WORD_W(WORD_W)) u_xnor_popcount (
    .a   (in_buf[pipe_w_q]),
    .b   (bus.w_data),
    .cnt (pc)
  );

  // In DECIDE the last word's popcount has not been added yet; fold it in here.
  assign acc_final = acc_q + ACC_W'(pc);

  // State register plus the registered in_ready, which stays low during reset
  // and first rises on the clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      in_ready_q <= (state_d == LOAD);
    end
  end

  // Next-state logic: load a vector, then COMPUTE/DECIDE per neuron, then hold the result.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (in_fire && last_word) state_d = COMPUTE;
      COMPUTE: if (last_w)               state_d = DECIDE;
      DECIDE:  state_d = last_n ? OUTPUT : COMPUTE;
      OUTPUT:  if (bus.out_ready)        state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Datapath: input buffer, word/neuron counters, ROM-latency pipe, accumulator, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      w_cnt_q    <= '0;
      n_cnt_q    <= '0;
      pipe_vld_q <= 1'b0;
      pipe_w_q   <= '0;
      acc_q      <= '0;
      out_bits_q <= '0;
      // NOTE: the buffer is a handful of flops, not a RAM macro, so it is reset
      // to make a mid-operation reset discard every trace of the old vector.
      for (int i = 0; i < N_WORDS; i++) in_buf[i] <= '0;
    end else begin
      pipe_vld_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (in_fire) begin
            in_buf[word_cnt_q] <= bus.in_data;
            word_cnt_q         <= last_word ? '0 : word_cnt_q + 1'b1;
          end
        end
        COMPUTE: begin
          pipe_vld_q <= 1'b1;
          pipe_w_q   <= w_cnt_q;
          w_cnt_q    <= last_w ? '0 : w_cnt_q + 1'b1;
          if (pipe_vld_q) acc_q <= acc_final;
        end
        DECIDE: begin
          out_bits_q[n_cnt_q] <= (acc_final >= thresh_n);
          acc_q               <= '0;
          n_cnt_q             <= last_n ? '0 : n_cnt_q + 1'b1;
        end
        OUTPUT: ;
        default: ;
      endcase
    end
  end

`ifdef BNN_THRESH_CFG_EN
  logic [ACC_W-1:0] thresh_q [N_NEURONS];

  // Threshold register file; writes only land while idle so a layer in flight
  // always sees one consistent set of thresholds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) thresh_q[i] <= THRESH_DEF;
    end else if (cfg_we && (state_q == LOAD) && (int'(cfg_idx) < N_NEURONS)) begin
      thresh_q[cfg_idx] <= cfg_thresh;
    end
  end

  assign thresh_n = thresh_q[n_cnt_q];
`else
  assign thresh_n = THRESH_DEF;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.busy      = (state_q != LOAD);
  assign bus.out_bits  = out_bits_q;
  assign bus.w_addr    = ADDR_W'(n_cnt_q) * ADDR_W'(N_WORDS) + ADDR_W'(w_cnt_q);

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed self-checking bench for bnn_layer_sequencer with a synchronous weight ROM model.
// Define BNN_THRESH_CFG_EN to also exercise the threshold configuration port.
module tb_bnn_layer_sequencer;

  localparam int WORD_W    = 8;
  localparam int N_WORDS   = 4;
  localparam int N_NEURONS = 8;
  localparam int LATENCY   = N_NEURONS * (N_WORDS + 1);

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [WORD_W-1:0] rom [N_NEURONS * N_WORDS];

`ifdef BNN_THRESH_CFG_EN
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [5:0] cfg_thresh;
`endif

  bnn_layer_sequencer_if #(
    .WORD_W(WORD_W), .N_WORDS(N_WORDS), .N_NEURONS(N_NEURONS)
  ) bus_if ();

  bnn_layer_sequencer #(
    .WORD_W(WORD_W), .N_WORDS(N_WORDS), .N_NEURONS(N_NEURONS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef BNN_THRESH_CFG_EN
    ,
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_thresh (cfg_thresh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) bus_if.w_data <= rom[bus_if.w_addr];

  task automatic set_neuron(input int n, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    rom[n*4+0] = a;
    rom[n*4+1] = b;
    rom[n*4+2] = c;
    rom[n*4+3] = d;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int n = 0; n < N_NEURONS; n++) set_neuron(n, v, v, v, v);
  endtask

  // Sends four words; returns #1 after the edge of the last handshake.
  task automatic send_vector(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    int wait_cnt;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = v[i];
      wait_cnt = 0;
      while (!bus_if.in_ready && wait_cnt < 100) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!bus_if.in_ready) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout word %0d: in_ready=%b required 1", i, bus_if.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus_if.in_valid = 1'b0;
  endtask

  // Counts clocks from the last input handshake until out_valid; 0 means timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic accept_output();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready); end
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_vec++; if (bus_if.out_bits !== 8'h00) begin n_err++; $display("FAIL reset_out_bits: got %h want 00", bus_if.out_bits); end
    n_vec++; if (bus_if.w_addr !== 5'd0) begin n_err++; $display("FAIL reset_w_addr: got %0d want 0", bus_if.w_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL release_in_ready_early: got %b want 0", bus_if.in_ready); end
    @(posedge clk);
    #1;
    n_vec++; if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", bus_if.in_ready); end
  endtask

  task automatic test_all_match();
    int lat;
    set_all(8'hFF);
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    n_vec++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL t2_busy: got %b want 1", bus_if.busy); end
    n_vec++; if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL t2_in_ready_compute: got %b want 0", bus_if.in_ready); end
    wait_result(lat);
    n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL t2_latency: got %0d want %0d", lat, LATENCY); end
    n_vec++; if (bus_if.out_bits !== 8'hFF) begin n_err++; $display("FAIL t2_out_bits: got %h want ff", bus_if.out_bits); end
    accept_output();
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL t2_out_valid_drop: got %b want 0", bus_if.out_valid); end
    n_vec++; if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL t2_back_to_load: got %b want 1", bus_if.in_ready); end
  endtask

  task automatic test_no_match();
    int lat;
    set_all(8'h00);
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_result(lat);
    n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL t3_latency: got %0d want %0d", lat, LATENCY); end
    n_vec++; if (bus_if.out_bits !== 8'h00) begin n_err++; $display("FAIL t3_out_bits: got %h want 00", bus_if.out_bits); end
    accept_output();
  endtask

  task automatic test_threshold_edge();
    int lat;
    // Neuron 0 no matches, neuron 3 exactly 16 matches, others 32.
    set_all(8'hFF);
    set_neuron(0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_neuron(3, 8'hFF, 8'hFF, 8'h00, 8'h00);
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_result(lat);
    n_vec++; if (bus_if.out_bits !== 8'hFE) begin n_err++; $display("FAIL t4_16_matches: got %h want fe", bus_if.out_bits); end
    accept_output();
    // Neuron 3 drops to 15 matches.
    set_neuron(3, 8'hFF, 8'h7F, 8'h00, 8'h00);
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_result(lat);
    n_vec++; if (bus_if.out_bits !== 8'hF6) begin n_err++; $display("FAIL t4_15_matches: got %h want f6", bus_if.out_bits); end
    accept_output();
  endtask

  task automatic test_output_hold();
    int lat;
    int bad;
    // Mixed input: neuron 1 copies it (32), neuron 2 inverts it (0), others all-zero weights (16).
    set_all(8'h00);
    set_neuron(1, 8'hAA, 8'h55, 8'hF0, 8'h0F);
    set_neuron(2, 8'h55, 8'hAA, 8'h0F, 8'hF0);
    send_vector(8'hAA, 8'h55, 8'hF0, 8'h0F);
    wait_result(lat);
    n_vec++; if (bus_if.out_bits !== 8'hFB) begin n_err++; $display("FAIL t5_out_bits: got %h want fb", bus_if.out_bits); end
    bad = 0;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h3C;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bits !== 8'hFB || bus_if.in_ready !== 1'b0) bad++;
    end
    bus_if.in_valid = 1'b0;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL t5_hold_stable: %0d bad cycles want 0", bad); end
    accept_output();
    n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL t5_out_valid_drop: got %b want 0", bus_if.out_valid); end
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL t5_busy_idle: got %b want 0", bus_if.busy); end
    n_vec++; if (bus_if.out_bits !== 8'hFB) begin n_err++; $display("FAIL t5_out_bits_kept: got %h want fb", bus_if.out_bits); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    set_all(8'hFF);
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    // Neuron 4 starts 20 clocks after the last handshake.
    repeat (22) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL t6_busy: got %b want 0", bus_if.busy); end
    n_vec++; if (bus_if.in_ready !== 1'b0) begin n_err++; $display("FAIL t6_in_ready: got %b want 0", bus_if.in_ready); end
    n_vec++; if (bus_if.out_bits !== 8'h00) begin n_err++; $display("FAIL t6_out_bits: got %h want 00", bus_if.out_bits); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL t6_no_partial: out_valid high %0d cycles want 0", seen); end
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_result(lat);
    n_vec++; if (lat !== LATENCY) begin n_err++; $display("FAIL t6_latency: got %0d want %0d", lat, LATENCY); end
    n_vec++; if (bus_if.out_bits !== 8'hFF) begin n_err++; $display("FAIL t6_out_bits_after: got %h want ff", bus_if.out_bits); end
    accept_output();
  endtask

`ifdef BNN_THRESH_CFG_EN
  task automatic test_thresh_cfg();
    int lat;
    set_all(8'hFF);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_thresh = 6'd33;
    @(negedge clk);
    cfg_we = 1'b0;
    send_vector(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    // Busy now: this write must be dropped.
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_thresh = 6'd33;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_result(lat);
    n_vec++; if (bus_if.out_bits !== 8'hFE) begin n_err++; $display("FAIL t7_out_bits: got %h want fe", bus_if.out_bits); end
    accept_output();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
`ifdef BNN_THRESH_CFG_EN
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_thresh = '0;
`endif
    set_all(8'h00);
    test_reset();
    test_all_match();
    test_no_match();
    test_threshold_edge();
    test_output_hold();
    test_mid_reset();
`ifdef BNN_THRESH_CFG_EN
    test_thresh_cfg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
